// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA timing receiver recovering pixel coordinates, data-enable, lock and timing errors
// Ports:
//   vga_clk, rst_n             clock and asynchronous active-low reset
//   pix_ce                     pixel strobe; every other input is sampled only while it is high
//   h_sync, v_sync             incoming syncs, asserted at level SYNC_POL
//   r_data, g_data, b_data     incoming pixel colour
//   pix_valid, pix_x, pix_y    visible-pixel pulse and its coordinates (one clock after the strobe)
//   rgb_out, frame_start       captured colour, pulse on pixel (0,0)
//   locked                     high only once full line and frame timing has been confirmed
//   err_line, err_frame        single-cycle pulses on a bad line / frame length
//   err_cnt                    saturating count of error pulses
module vga_sync_rx #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        vga_clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [7:0]  r_data,
   input  logic [7:0]  g_data,
   input  logic [7:0]  b_data,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic [23:0] rgb_out,
   output logic        locked,
   output logic        frame_start,
   output logic        err_line,
   output logic        err_frame,
   output logic [7:0]  err_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HX0 = H_SYNC + H_BP;
   localparam int VY0 = V_SYNC + V_BP;
   typedef enum logic [1:0] {SEARCH, HLOCK, VSEEN, LOCKED} state_t;
   state_t      state;
   logic        h_prev, v_prev, one_good;
   logic [11:0] hcnt, hcnt_n;
   logic [10:0] vcnt, vcnt_n;
   logic        h_edge, v_edge, line_ok, frame_ok, e_line, e_frame, timeout, valid;
   logic [10:0] px;
   logic [9:0]  py;
   logic [8:0]  ec_sum;
   assign h_edge   = (h_sync == SYNC_POL) & ~h_prev;
   assign v_edge   = (v_sync == SYNC_POL) & ~v_prev;
   // line length hcnt+1 == H_TOTAL, frame length vcnt+1 == V_TOTAL
   assign line_ok  = hcnt == 12'(H_TOTAL - 1);
   assign frame_ok = vcnt == 11'(V_TOTAL - 1);
   assign e_line   = h_edge & ~line_ok & (state != SEARCH);
   assign e_frame  = v_edge & ~frame_ok & (state == VSEEN || state == LOCKED);
   assign hcnt_n   = h_edge ? '0 : hcnt + 12'(~&hcnt);
   assign vcnt_n   = v_edge ? '0 : vcnt + 11'(h_edge & ~&vcnt);
   // a missing h edge shows up as hcnt running past two line lengths
   assign timeout  = hcnt_n >= 12'(2 * H_TOTAL);
   assign px       = 11'(hcnt_n - 12'(HX0));
   assign py       = 10'(vcnt_n - 11'(VY0));
   // entry into LOCKED happens at vcnt_n == 0, never inside the window
   assign valid    = state == LOCKED && !e_line && !e_frame && !timeout
                     && hcnt_n >= 12'(HX0) && hcnt_n < 12'(HX0 + H_ACTIVE)
                     && vcnt_n >= 11'(VY0) && vcnt_n < 11'(VY0 + V_ACTIVE);
   assign ec_sum   = {1'b0, err_cnt} + 9'(e_line) + 9'(e_frame);
   assign locked   = state == LOCKED;
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SEARCH;
         h_prev      <= 1'b0;
         v_prev      <= 1'b0;
         one_good    <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         rgb_out     <= '0;
         frame_start <= 1'b0;
         err_line    <= 1'b0;
         err_frame   <= 1'b0;
         err_cnt     <= '0;
      end else begin
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         err_line    <= 1'b0;
         err_frame   <= 1'b0;
         if (pix_ce) begin
            h_prev      <= h_sync == SYNC_POL;
            v_prev      <= v_sync == SYNC_POL;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            pix_valid   <= valid;
            frame_start <= valid && px == '0 && py == '0;
            err_line    <= e_line;
            err_frame   <= e_frame;
            err_cnt     <= ec_sum[8] ? 8'hff : ec_sum[7:0];
            if (valid) begin
               pix_x   <= px;
               pix_y   <= py;
               rgb_out <= {r_data, g_data, b_data};
            end
            if (e_line || e_frame || timeout) begin
               state    <= SEARCH;
               one_good <= 1'b0;
            end else begin
               case (state)
                  // two consecutive good line lengths are needed; one_good remembers the first
                  SEARCH: if (h_edge) begin
                     one_good <= line_ok & ~one_good;
                     if (line_ok && one_good) state <= HLOCK;
                  end
                  HLOCK:  if (v_edge) state <= VSEEN;
                  VSEEN:  if (v_edge) state <= LOCKED;
                  default: ;
               endcase
            end
         end
      end
   end
endmodule
